// File: rtl/video_ctrl_pkg.sv
// Shared constants for the video timing run-control sequencer.
// State and opcode encodings are plain localparams so legacy code can reuse them.
package video_ctrl_pkg;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_LOCK  = 3'd1;
  localparam logic [2:0] SETTLE     = 3'd2;
  localparam logic [2:0] RUN        = 3'd3;
  localparam logic [2:0] PAUSE_PEND = 3'd4;
  localparam logic [2:0] PAUSED     = 3'd5;
  localparam logic [2:0] STOP_PEND  = 3'd6;
  localparam logic [2:0] FAULT      = 3'd7;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_STOP   = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  // One counter serves both the settle countdown and the watchdog, so it is
  // sized for whichever of the two limits is larger.
  function automatic int timer_width(input int settle_cycles, input int timeout_cycles);
    int m;
    m = (settle_cycles > timeout_cycles) ? settle_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/vtc_cycle_timer.sv
// Loadable cycle counter: counts down during settle, up as the vsync watchdog.
// Holding all controls low freezes the count.
module vtc_cycle_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clr,
  input  logic         i_dec,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/video_timing_ctrl.sv
// Run-control sequencer for the video sync generator: PLL-lock wait, settle,
// frame-aligned stop/pause, vsync watchdog with auto-restart, frame counting.
//
// state      | meaning
// IDLE       | generator off, waiting for START
// WAIT_LOCK  | waiting for pixel PLL lock
// SETTLE     | lock seen, holding off SETTLE_CYCLES before enabling
// RUN        | generator enabled, watchdog running
// PAUSE_PEND | PAUSE accepted, waiting for next frame boundary
// PAUSED     | generator paused, watchdog frozen
// STOP_PEND  | STOP accepted, waiting for next frame boundary
// FAULT      | vsync lost; one-cycle disable before re-settling
module video_timing_ctrl
  import video_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 2600000,
  parameter int FCNT_W         = 16
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic              i_pll_locked,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd_op,
  output logic              o_cmd_ready,
  output logic              o_cmd_err,
  input  logic              i_gen_vsync,
  output logic              o_gen_enable,
  output logic              o_gen_pause,
  output logic              o_running,
  output logic              o_paused,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_timeout_err,
  output logic [2:0]        o_state
);

  localparam int TIMER_W = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WD_LIMIT    = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        r_state;
  logic              r_gen_enable;
  logic              r_gen_pause;
  logic              r_cmd_err;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_timeout_err;
  logic              r_vs_d;

  logic [2:0]         w_nxt_state;
  logic               w_nxt_enable;
  logic               w_nxt_pause;
  logic               w_nxt_cmd_err;
  logic               w_fcnt_inc;
  logic               w_fcnt_clr;
  logic               w_terr_set;
  logic               w_terr_clr;
  logic               w_t_load;
  logic               w_t_clr;
  logic               w_t_dec;
  logic               w_t_inc;
  logic [TIMER_W-1:0] w_count;
  logic               w_cmd_acc;
  logic               w_vs_rise;
  logic               w_active;
  logic               w_pll_lost;
  logic               w_wd_expire;

  assign o_cmd_ready = (r_state == IDLE) || (r_state == RUN) || (r_state == PAUSED);
  assign o_running   = w_active;
  assign o_paused    = (r_state == PAUSED);
  assign o_state     = r_state;

  assign w_cmd_acc   = i_cmd_valid && o_cmd_ready;
  assign w_vs_rise   = i_gen_vsync && !r_vs_d && r_gen_enable;
  assign w_active    = (r_state == RUN) || (r_state == PAUSE_PEND) || (r_state == STOP_PEND);
  assign w_pll_lost  = !i_pll_locked && (r_state != IDLE) && (r_state != WAIT_LOCK);
  assign w_wd_expire = w_active && (w_count == WD_LIMIT);

  vtc_cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .i_clk      (i_pclk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_t_load),
    .i_load_val (SETTLE_LOAD),
    .i_clr      (w_t_clr),
    .i_dec      (w_t_dec),
    .i_inc      (w_t_inc),
    .o_count    (w_count)
  );

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_enable  = r_gen_enable;
    w_nxt_pause   = r_gen_pause;
    w_nxt_cmd_err = 1'b0;
    w_fcnt_inc    = 1'b0;
    w_fcnt_clr    = 1'b0;
    w_terr_set    = 1'b0;
    w_terr_clr    = 1'b0;
    w_t_load      = 1'b0;
    w_t_clr       = 1'b0;
    w_t_dec       = 1'b0;
    w_t_inc       = 1'b0;

    // Lock loss beats everything; any pending stop/pause is dropped with it.
    if (w_pll_lost) begin
      w_nxt_state  = WAIT_LOCK;
      w_nxt_enable = 1'b0;
      w_nxt_pause  = 1'b0;
      w_t_clr      = 1'b1;
    end else if (w_wd_expire) begin
      w_nxt_state  = FAULT;
      w_nxt_enable = 1'b0;
      w_nxt_pause  = 1'b0;
      w_terr_set   = 1'b1;
      w_t_clr      = 1'b1;
    end else begin
      if (w_active) begin
        if (w_vs_rise) begin
          w_fcnt_inc = 1'b1;
          w_t_clr    = 1'b1;
        end else begin
          w_t_inc = 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_cmd_acc) begin
            if (i_cmd_op == OP_START) begin
              w_nxt_state = WAIT_LOCK;
              w_fcnt_clr  = 1'b1;
              w_terr_clr  = 1'b1;
            end else begin
              w_nxt_cmd_err = 1'b1;
            end
          end
        end
        WAIT_LOCK: begin
          if (i_pll_locked) begin
            w_nxt_state = SETTLE;
            w_t_load    = 1'b1;
          end
        end
        SETTLE: begin
          if (w_count == '0) begin
            w_nxt_state  = RUN;
            w_nxt_enable = 1'b1;
            w_t_clr      = 1'b1;
          end else begin
            w_t_dec = 1'b1;
          end
        end
        RUN: begin
          // A command on a vsync edge still only arms the pending state, so
          // the stop/pause lands on the following frame boundary.
          if (w_cmd_acc) begin
            case (i_cmd_op)
              OP_STOP:  w_nxt_state = STOP_PEND;
              OP_PAUSE: w_nxt_state = PAUSE_PEND;
              default:  w_nxt_cmd_err = 1'b1;
            endcase
          end
        end
        PAUSE_PEND: begin
          if (w_vs_rise) begin
            w_nxt_state = PAUSED;
            w_nxt_pause = 1'b1;
          end
        end
        STOP_PEND: begin
          if (w_vs_rise) begin
            w_nxt_state  = IDLE;
            w_nxt_enable = 1'b0;
          end
        end
        PAUSED: begin
          if (w_cmd_acc) begin
            case (i_cmd_op)
              OP_RESUME: begin
                w_nxt_state = RUN;
                w_nxt_pause = 1'b0;
                w_t_clr     = 1'b1;
              end
              OP_STOP: begin
                w_nxt_state  = IDLE;
                w_nxt_enable = 1'b0;
                w_nxt_pause  = 1'b0;
                w_t_clr      = 1'b1;
              end
              default: w_nxt_cmd_err = 1'b1;
            endcase
          end
        end
        FAULT: begin
          w_nxt_state = SETTLE;
          w_t_load    = 1'b1;
        end
        default: begin
          w_nxt_state  = IDLE;
          w_nxt_enable = 1'b0;
          w_nxt_pause  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_gen_enable  <= 1'b0;
      r_gen_pause   <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_frame_cnt   <= '0;
      r_timeout_err <= 1'b0;
      r_vs_d        <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_gen_enable <= w_nxt_enable;
      r_gen_pause  <= w_nxt_pause;
      r_cmd_err    <= w_nxt_cmd_err;
      r_vs_d       <= i_gen_vsync;
      if (w_fcnt_clr) begin
        r_frame_cnt <= '0;
      end else if (w_fcnt_inc) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_terr_clr) begin
        r_timeout_err <= 1'b0;
      end else if (w_terr_set) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_gen_enable  = r_gen_enable;
  assign o_gen_pause   = r_gen_pause;
  assign o_cmd_err     = r_cmd_err;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl with a 60-cycle vsync model (5 high).
module tb_video_timing_ctrl;
  import video_ctrl_pkg::*;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        gen_vsync;
  logic        cmd_ready;
  logic        cmd_err;
  logic        gen_enable;
  logic        gen_pause;
  logic        running;
  logic        paused;
  logic [15:0] frame_cnt;
  logic        timeout_err;
  logic [2:0]  state_o;

  int checks   = 0;
  int failures = 0;
  int vs_ph    = 0;
  bit vs_on    = 1'b0;

  video_timing_ctrl #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (100),
    .FCNT_W         (16)
  ) dut (
    .i_pclk        (pclk),
    .i_rst_n       (rst_n),
    .i_pll_locked  (pll_locked),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_op      (cmd_op),
    .o_cmd_ready   (cmd_ready),
    .o_cmd_err     (cmd_err),
    .i_gen_vsync   (gen_vsync),
    .o_gen_enable  (gen_enable),
    .o_gen_pause   (gen_pause),
    .o_running     (running),
    .o_paused      (paused),
    .o_frame_cnt   (frame_cnt),
    .o_timeout_err (timeout_err),
    .o_state       (state_o)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock edge; afterwards gen_vsync holds the level the next edge will see.
  task automatic step();
    @(posedge pclk);
    #1;
    if (vs_on) vs_ph = (vs_ph == 59) ? 0 : vs_ph + 1;
    gen_vsync = vs_on && (vs_ph < 5);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vs_start(input int ph);
    vs_on     = 1'b1;
    vs_ph     = ph;
    gen_vsync = (ph < 5);
  endtask

  task automatic vs_stop();
    vs_on     = 1'b0;
    gen_vsync = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    gen_vsync  = 1'b0;
    #12;
    check("rst_state", state_o, IDLE);
    check("rst_enable", gen_enable, 0);
    check("rst_pause", gen_pause, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_cmd_err", cmd_err, 0);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;

    // 1: start, enable exactly 17 cycles after acceptance, count 3 frames
    cmd(OP_START);
    check("t1_wait_lock", state_o, WAIT_LOCK);
    check("t1_ready_low", cmd_ready, 0);
    step();
    check("t1_settle", state_o, SETTLE);
    for (int i = 2; i <= 16; i++) begin
      check("t1_en_low", gen_enable, 0);
      step();
    end
    check("t1_en_low_16", gen_enable, 0);
    step();
    check("t1_en_17", gen_enable, 1);
    check("t1_run", state_o, RUN);
    check("t1_running", running, 1);
    vs_start(0);
    steps(180);
    check("t1_fcnt3", frame_cnt, 3);
    steps(30);
    check("t1_fcnt4", frame_cnt, 4);

    // 2: pause mid-frame, applied at next vsync; frozen watchdog; resume
    cmd(OP_PAUSE);
    check("t2_pend", state_o, PAUSE_PEND);
    check("t2_pause_low", gen_pause, 0);
    steps(29);
    check("t2_pause_low_pre", gen_pause, 0);
    step();
    check("t2_pause_high", gen_pause, 1);
    check("t2_paused", paused, 1);
    check("t2_fcnt5", frame_cnt, 5);
    vs_stop();
    steps(500);
    check("t2_no_terr", timeout_err, 0);
    check("t2_still_paused", state_o, PAUSED);
    check("t2_fcnt_frozen", frame_cnt, 5);
    cmd(OP_RESUME);
    check("t2_resume_pause", gen_pause, 0);
    check("t2_resume_run", state_o, RUN);
    vs_start(0);
    steps(30);
    check("t2_fcnt6", frame_cnt, 6);

    // 3: stop mid-frame, applied at next vsync
    cmd(OP_STOP);
    check("t3_pend", state_o, STOP_PEND);
    check("t3_ready_low", cmd_ready, 0);
    steps(29);
    check("t3_en_held", gen_enable, 1);
    step();
    check("t3_en_low", gen_enable, 0);
    check("t3_idle", state_o, IDLE);
    check("t3_ready", cmd_ready, 1);
    check("t3_fcnt7", frame_cnt, 7);

    // 4: vsync silent -> watchdog fault, one-cycle disable, auto-restart
    vs_stop();
    cmd(OP_START);
    check("t4_fcnt_clr", frame_cnt, 0);
    steps(17);
    check("t4_run", state_o, RUN);
    steps(99);
    check("t4_pre_fault", state_o, RUN);
    check("t4_pre_terr", timeout_err, 0);
    step();
    check("t4_fault", state_o, FAULT);
    check("t4_terr", timeout_err, 1);
    check("t4_fault_en", gen_enable, 0);
    step();
    check("t4_resettle", state_o, SETTLE);
    steps(15);
    check("t4_en_low", gen_enable, 0);
    step();
    check("t4_en_back", gen_enable, 1);
    vs_start(0);
    steps(30);
    check("t4_fcnt1", frame_cnt, 1);
    check("t4_terr_sticky", timeout_err, 1);

    // 5: lock loss while stop pending
    cmd(OP_STOP);
    check("t5_pend", state_o, STOP_PEND);
    pll_locked = 1'b0;
    step();
    check("t5_wait_lock", state_o, WAIT_LOCK);
    check("t5_en_low", gen_enable, 0);
    check("t5_not_running", running, 0);
    steps(3);
    check("t5_hold", state_o, WAIT_LOCK);
    pll_locked = 1'b1;
    step();
    check("t5_settle", state_o, SETTLE);
    steps(15);
    check("t5_en_low_settle", gen_enable, 0);
    step();
    check("t5_en_back", gen_enable, 1);
    check("t5_stop_dropped", state_o, RUN);

    // 6: illegal commands, stop from paused
    cmd(OP_RESUME);
    check("t6_err_run", cmd_err, 1);
    check("t6_state_run", state_o, RUN);
    step();
    check("t6_err_clr", cmd_err, 0);
    cmd(OP_PAUSE);
    for (int i = 0; i < 70 && !paused; i++) step();
    check("t6_paused", paused, 1);
    check("t6_pause_out", gen_pause, 1);
    cmd(OP_START);
    check("t6_err_paused", cmd_err, 1);
    check("t6_state_paused", state_o, PAUSED);
    step();
    check("t6_err_clr2", cmd_err, 0);
    cmd(OP_STOP);
    check("t6_idle", state_o, IDLE);
    check("t6_pause_low", gen_pause, 0);
    check("t6_en_low", gen_enable, 0);
    cmd(OP_STOP);
    check("t6_err_idle", cmd_err, 1);
    check("t6_terr_before", timeout_err, 1);
    cmd(OP_START);
    check("t6_terr_cleared", timeout_err, 0);
    check("t6_fcnt_cleared", frame_cnt, 0);
    steps(17);
    check("t6_en_again", gen_enable, 1);

    // reset mid-run drops enable without a clock edge
    rst_n = 1'b0;
    #2;
    check("async_rst_en", gen_enable, 0);
    check("async_rst_state", state_o, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Run-control sequencer for the video sync generator: owns its enable and pause inputs. Accepts START/STOP/PAUSE/RESUME commands over a valid/ready handshake. Enforces a PLL-lock wait and settle delay before enabling, and applies STOP/PAUSE only at frame (vsync) boundaries. Monitors vsync with a watchdog and auto-restarts the generator on loss; counts frames for status.

Parameters:
SETTLE_CYCLES, 1024, pclk cycles held after pll_locked before enabling the generator (>=1)
TIMEOUT_CYCLES, 2600000, max pclk cycles between vsync rises before a fault (must exceed H_TOTAL*V_TOTAL of the slowest mode)
FCNT_W, 16, frame counter width

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  pixel PLL lock, already synchronous to pclk
cmd_valid  in  1  command request
cmd_op  in  2  0=START 1=STOP 2=PAUSE 3=RESUME
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_err  out  1  one-cycle pulse: accepted opcode illegal in current state, otherwise ignored
gen_vsync  in  1  generator positive-polarity vsync (ng_vs)
gen_enable  out  1  to generator enable
gen_pause  out  1  to generator pause
running  out  1  state is RUN, PAUSE_PEND or STOP_PEND
paused  out  1  state is PAUSED
frame_cnt  out  FCNT_W  vsync rises seen while enabled and not paused; wraps
timeout_err  out  1  sticky watchdog fault flag
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset values: state IDLE; gen_enable=0, gen_pause=0, cmd_err=0, frame_cnt=0, timeout_err=0, both counters 0, vs_d=0.
- All outputs are registered except cmd_ready, running, paused and state_o, which decode the state combinationally.
- cmd_ready=1 in IDLE, RUN and PAUSED; 0 in every other state.
- Legal commands:
  - IDLE: START.
  - RUN: STOP, PAUSE.
  - PAUSED: RESUME, STOP.
  - Any other accepted opcode pulses cmd_err the next cycle and changes nothing.
- vs_rise = gen_vsync & ~vs_d, where vs_d is gen_vsync registered. vs_rise is qualified by gen_enable.
- States and transitions:
  - IDLE: START accepted -> WAIT_LOCK; clear frame_cnt and timeout_err.
  - WAIT_LOCK: pll_locked=1 -> SETTLE; load cnt=SETTLE_CYCLES-1.
  - SETTLE: decrement cnt; at cnt==0 -> RUN, gen_enable=1 on that same edge, watchdog cleared.
  - RUN: PAUSE -> PAUSE_PEND; STOP -> STOP_PEND.
  - PAUSE_PEND: vs_rise -> PAUSED, gen_pause=1 on the following edge.
  - STOP_PEND: vs_rise -> IDLE, gen_enable=0 on the following edge.
  - PAUSED: watchdog frozen. RESUME -> RUN, gen_pause=0 next edge, watchdog cleared. STOP -> IDLE immediately, gen_enable=0 and gen_pause=0.
  - FAULT: gen_enable=0 for exactly one cycle, then -> SETTLE (auto-restart).
- Watchdog:
  - Increments each cycle in RUN, PAUSE_PEND and STOP_PEND; cleared on vs_rise.
  - Reaching TIMEOUT_CYCLES-1 -> FAULT, timeout_err=1.
  - timeout_err stays set until START is accepted or reset.
- frame_cnt increments on vs_rise in RUN, PAUSE_PEND and STOP_PEND. Interlaced modes count fields.
- Priority per cycle, highest first:
  1. pll_locked=0 in any state other than IDLE/WAIT_LOCK -> WAIT_LOCK; gen_enable=0, gen_pause=0; pending PAUSE/STOP discarded.
  2. Watchdog expiry.
  3. vs_rise.
  4. Command.
- Simultaneous cases:
  - STOP accepted in RUN on a vs_rise cycle: frame counted, state goes to STOP_PEND, and the stop waits for the next vs_rise.
  - PAUSE accepted in RUN on a vs_rise cycle: same rule, enters PAUSE_PEND.
- Reset mid-operation drops gen_enable asynchronously. The generator then restarts from Hcnt=0/Vcnt=0 on the next START.

Decomposition:
- Package video_ctrl_pkg:
  - state encoding constants IDLE=0, WAIT_LOCK=1, SETTLE=2, RUN=3, PAUSE_PEND=4, PAUSED=5, STOP_PEND=6, FAULT=7.
  - opcode constants OP_START/OP_STOP/OP_PAUSE/OP_RESUME.
- One sub-module, vtc_cycle_timer: loadable down/up counter shared by SETTLE (countdown) and the watchdog (count-up with clear/freeze). Width is derived from max(SETTLE_CYCLES, TIMEOUT_CYCLES).

Test Plan:
Benches use SETTLE_CYCLES=16, TIMEOUT_CYCLES=100 and a behavioural vsync model with a 60-cycle period, high for 5 cycles.
1. Reset, pll_locked=1, START -> cmd_ready low, gen_enable rises exactly 17 cycles after acceptance (1 into WAIT_LOCK + 16 settle); frame_cnt=3 after 3 vsync pulses.
2. PAUSE in RUN mid-frame -> gen_pause stays 0 until the next vs rise, asserts 1 cycle after it; frame_cnt frozen; 500 cycles without vsync raise no timeout_err; RESUME -> gen_pause=0 next cycle.
3. STOP mid-frame -> gen_enable held until the next vs rise, low 1 cycle after it; state_o=0; cmd_ready=1.
4. Vsync model silenced in RUN -> timeout_err=1 and state FAULT at watchdog count 99; gen_enable low 1 cycle, then SETTLE; gen_enable=1 16 cycles later; timeout_err still 1 until the next START.
5. pll_locked dropped while STOP_PEND -> next cycle gen_enable=0, state WAIT_LOCK, stop discarded; relock -> enabled again 16 cycles later.
6. RESUME in RUN and START in PAUSED -> cmd_err one-cycle pulse each, state unchanged; STOP in PAUSED -> IDLE in 1 cycle, gen_pause=0, gen_enable=0.
